// File: rtl/pipeline_pkg.sv
// Shared pipeline types: EX operand forward encodings and the per-stage shadow slot record.
// Pure declarations, no logic and no latency; used by pipeline_forward and pipeline_EX.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic       regwr;
        logic [4:0] wraddr;
        logic       memread;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    function automatic logic slot_writes(input slot_t s, input logic [4:0] r);
        return s.valid && s.regwr && (s.wraddr == r);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
        return (en && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Picks the forward source for one ID source register; pure combinational, zero latency.
// The EX slot is checked before MEM so the youngest producer wins; no flow control.
module fwd_match
    import pipeline_pkg::*;
(
    input  logic [4:0] reg_num,
    input  logic       use_reg,
    input  slot_t      ex_slot,
    input  slot_t      mem_slot,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_REG;
        if (use_reg && reg_num != 5'd0) begin
            if (slot_writes(ex_slot, reg_num)) begin
                sel = FWD_EXMEM;
            end else if (slot_writes(mem_slot, reg_num)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/pipeline_forward.sv
// Forwarding/hazard unit: ForwardA/B registered 1 cycle (aligned with EX), Stall combinational (load-use).
// Stall holds PC and IF/ID; optional counters under PIPELINE_FORWARD_STATS_EN.
module pipeline_forward
    import pipeline_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UseRs,
    input  logic       ID_UseRt,
    input  logic       ID_RegWr,
    input  logic [4:0] ID_WrAddr,
    input  logic       ID_MemRead,
    input  logic       ID_Valid,
    input  logic       Flush,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic       Stall
`ifdef PIPELINE_FORWARD_STATS_EN
    ,
    output logic [15:0] StallCnt,
    output logic [15:0] FwdCnt
`endif
);

    slot_t      id_slot;
    slot_t      ex_slot;
    slot_t      mem_slot;
    slot_t      wb_slot;
    logic       rs_hit;
    logic       rt_hit;
    logic       load_ex;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    always_comb begin
        id_slot.valid   = 1'b1;
        id_slot.regwr   = ID_RegWr;
        id_slot.wraddr  = ID_WrAddr;
        id_slot.memread = ID_MemRead;
    end

    assign rs_hit = ID_UseRs && (ID_rs == ex_slot.wraddr);
    assign rt_hit = ID_UseRt && (ID_rt == ex_slot.wraddr);

    assign Stall = !reset && ID_Valid && ex_slot.valid && ex_slot.memread
                && (ex_slot.wraddr != 5'd0) && (rs_hit || rt_hit);

    // Flush squashes regardless of Stall, so both simply force a bubble.
    assign load_ex = ID_Valid && !Stall && !Flush;

    fwd_match u_match_rs (
        .reg_num  (ID_rs),
        .use_reg  (ID_UseRs),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .sel      (sel_a)
    );

    fwd_match u_match_rt (
        .reg_num  (ID_rt),
        .use_reg  (ID_UseRt),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .sel      (sel_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_slot  <= SLOT_BUBBLE;
            mem_slot <= SLOT_BUBBLE;
            wb_slot  <= SLOT_BUBBLE;
            ForwardA <= FWD_REG;
            ForwardB <= FWD_REG;
        end else begin
            ex_slot  <= load_ex ? id_slot : SLOT_BUBBLE;
            mem_slot <= ex_slot;
            wb_slot  <= mem_slot;
            ForwardA <= load_ex ? sel_a : FWD_REG;
            ForwardB <= load_ex ? sel_b : FWD_REG;
        end
    end

    // WB never forwards: the register file writes before it is read in the same cycle.
    logic unused_wb;
    assign unused_wb = ^wb_slot;

`ifdef PIPELINE_FORWARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCnt <= 16'd0;
            FwdCnt   <= 16'd0;
        end else begin
            StallCnt <= sat_inc(StallCnt, Stall && !Flush);
            FwdCnt   <= sat_inc(FwdCnt, (ForwardA != FWD_REG) || (ForwardB != FWD_REG));
        end
    end
`endif

endmodule
